ir_cmd_sequencer: RTL and testbench

- Sits between the IR receiver (`ir_control`) and user logic.
- Takes decoded 32-bit NEC frames and repeat-code pulses, validates them, and turns key holds into rate-limited auto-repeat commands.
- Buffers commands in a small FIFO with a valid/ready output handshake, so consumers never see raw IR timing.

---
 rtl/ir_cmd_sequencer.sv | 175 +++++++++++++++++
 tb/tb_ir_cmd_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ir_cmd_sequencer.sv
// NEC command sequencer: validates decoded IR frames, turns key holds into
// rate-limited auto-repeats and queues commands in a small FWFT FIFO.
module ir_cmd_sequencer #(
  parameter logic [7:0]  DEV_ADDR     = 8'h00,
  parameter bit          CHECK_ADDR   = 1'b1,
  parameter int unsigned CNT_W        = 26,
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000,
  parameter int unsigned HOLD_TIMEOUT = 7_500_000,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_valid,
  input  logic [31:0]                  frame_data,
  input  logic                         repeat_pulse,
  output logic                         cmd_valid,
  output logic [7:0]                   cmd_data,
  output logic                         cmd_is_repeat,
  input  logic                         cmd_ready,
  output logic                         bad_frame,
  output logic [7:0]                   drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  typedef struct packed {
    logic       rpt;
    logic [7:0] cmd;
  } entry_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [0:0]       state, state_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [CNT_W-1:0] emit_cnt, emit_cnt_nxt;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;
  logic [7:0]       last_cmd, last_cmd_nxt;
  logic             bad_frame_nxt;
  logic             frame_good_c;
  logic             push_c;
  entry_t           push_entry_c;

  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [LVL_W-1:0] level_nxt, remain_c;
  logic             pop_c, full_c, wr_en_c, drop_c;
  entry_t           head_nxt;

  // Frame integrity: both inverted bytes must match, address optionally filtered
  always_comb begin
    frame_good_c = (frame_data[7:0]   == ~frame_data[15:8]) &&
                   (frame_data[23:16] == ~frame_data[31:24]) &&
                   (!CHECK_ADDR || (frame_data[7:0] == DEV_ADDR));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      emit_cnt  <= '0;
      idle_cnt  <= '0;
      last_cmd  <= '0;
      bad_frame <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_cnt_nxt;
      emit_cnt  <= emit_cnt_nxt;
      idle_cnt  <= idle_cnt_nxt;
      last_cmd  <= last_cmd_nxt;
      bad_frame <= bad_frame_nxt;
    end
  end

  // Next-state: a frame always wins over a same-cycle repeat; timeout wins over a late repeat
  always_comb begin
    state_nxt     = state;
    hold_cnt_nxt  = hold_cnt;
    emit_cnt_nxt  = emit_cnt;
    idle_cnt_nxt  = idle_cnt;
    last_cmd_nxt  = last_cmd;
    bad_frame_nxt = 1'b0;
    push_c        = 1'b0;
    push_entry_c  = '{rpt: 1'b0, cmd: frame_data[23:16]};

    if (state == ST_HELD) begin
      hold_cnt_nxt = sat_inc(hold_cnt);
      emit_cnt_nxt = sat_inc(emit_cnt);
      idle_cnt_nxt = sat_inc(idle_cnt);
    end

    if (frame_valid) begin
      if (frame_good_c) begin
        push_c       = 1'b1;
        push_entry_c = '{rpt: 1'b0, cmd: frame_data[23:16]};
        last_cmd_nxt = frame_data[23:16];
        hold_cnt_nxt = '0;
        emit_cnt_nxt = '0;
        idle_cnt_nxt = '0;
        state_nxt    = ST_HELD;
      end else begin
        bad_frame_nxt = 1'b1;
        state_nxt     = ST_IDLE;
      end
    end else if (state == ST_HELD) begin
      if (idle_cnt >= CNT_W'(HOLD_TIMEOUT)) begin
        state_nxt = ST_IDLE;
      end else if (repeat_pulse) begin
        idle_cnt_nxt = '0;
        if ((hold_cnt >= CNT_W'(REPEAT_DELAY)) && (emit_cnt >= CNT_W'(REPEAT_RATE))) begin
          push_c       = 1'b1;
          push_entry_c = '{rpt: 1'b1, cmd: last_cmd};
          emit_cnt_nxt = '0;
        end
      end
    end
  end

  // FIFO control: a push into a full FIFO survives only if the head leaves the same cycle
  always_comb begin
    pop_c      = cmd_ready && (fifo_level != '0);
    full_c     = (fifo_level == LVL_W'(FIFO_DEPTH));
    wr_en_c    = push_c && (!full_c || pop_c);
    drop_c     = push_c && full_c && !pop_c;
    remain_c   = fifo_level - LVL_W'(pop_c);
    level_nxt  = remain_c + LVL_W'(wr_en_c);
    rd_ptr_nxt = pop_c ? ptr_inc(rd_ptr) : rd_ptr;
    head_nxt   = (remain_c == '0) ? push_entry_c : mem[rd_ptr_nxt];
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_ptr] <= push_entry_c;
    end
  end

  // Head registers present the next head so the FIFO looks first-word-fall-through
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_level    <= '0;
      cmd_valid     <= 1'b0;
      cmd_data      <= '0;
      cmd_is_repeat <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      rd_ptr     <= rd_ptr_nxt;
      fifo_level <= level_nxt;
      cmd_valid  <= (level_nxt != '0);
      if (wr_en_c) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (level_nxt != '0) begin
        cmd_data      <= head_nxt.cmd;
        cmd_is_repeat <= head_nxt.rpt;
      end
      if (drop_c && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ir_cmd_sequencer.sv
// Directed bench for ir_cmd_sequencer with shortened hold/repeat timing.
module tb_ir_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_valid = 1'b0;
  logic [31:0] frame_data = '0;
  logic        repeat_pulse = 1'b0;
  logic        cmd_ready = 1'b1;

  logic        cmd_valid, cmd_is_repeat, bad_frame;
  logic [7:0]  cmd_data, drop_cnt;
  logic [2:0]  fifo_level;

  logic        cmd_valid_a, cmd_is_repeat_a, bad_frame_a;
  logic [7:0]  cmd_data_a, drop_cnt_a;
  logic [2:0]  fifo_level_a;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ir_cmd_sequencer #(
    .DEV_ADDR(8'h00), .CHECK_ADDR(1'b1), .CNT_W(26),
    .REPEAT_DELAY(20), .REPEAT_RATE(5), .HOLD_TIMEOUT(30), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_data(frame_data),
    .repeat_pulse(repeat_pulse), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_is_repeat(cmd_is_repeat), .cmd_ready(cmd_ready), .bad_frame(bad_frame),
    .drop_cnt(drop_cnt), .fifo_level(fifo_level)
  );

  ir_cmd_sequencer #(
    .DEV_ADDR(8'h04), .CHECK_ADDR(1'b1), .CNT_W(26),
    .REPEAT_DELAY(20), .REPEAT_RATE(5), .HOLD_TIMEOUT(30), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_data(frame_data),
    .repeat_pulse(repeat_pulse), .cmd_valid(cmd_valid_a), .cmd_data(cmd_data_a),
    .cmd_is_repeat(cmd_is_repeat_a), .cmd_ready(cmd_ready), .bad_frame(bad_frame_a),
    .drop_cnt(drop_cnt_a), .fifo_level(fifo_level_a)
  );

  function automatic logic [31:0] nec(input logic [7:0] a, input logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_frame(input logic [31:0] d);
    frame_valid = 1'b1;
    frame_data  = d;
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic do_repeat();
    repeat_pulse = 1'b1;
    tick();
    repeat_pulse = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", cmd_valid); end
    n_cmp++; if (cmd_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", cmd_data); end
    n_cmp++; if (cmd_is_repeat !== 1'b0) begin n_err++; $display("FAIL rst_rpt: got %b want 0", cmd_is_repeat); end
    n_cmp++; if (bad_frame !== 1'b0) begin n_err++; $display("FAIL rst_bad: got %b want 0", bad_frame); end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL rst_drop: got %0d want 0", drop_cnt); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_good_frame();
    cmd_ready = 1'b1;
    do_frame(32'hE51A_FF00);
    n_cmp++; if (cmd_valid !== 1'b1) begin n_err++; $display("FAIL good_valid: got %b want 1", cmd_valid); end
    n_cmp++; if (cmd_data !== 8'h1A) begin n_err++; $display("FAIL good_data: got %h want 1a", cmd_data); end
    n_cmp++; if (cmd_is_repeat !== 1'b0) begin n_err++; $display("FAIL good_rpt: got %b want 0", cmd_is_repeat); end
    n_cmp++; if (bad_frame !== 1'b0) begin n_err++; $display("FAIL good_bad: got %b want 0", bad_frame); end
    n_cmp++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL good_level: got %0d want 1", fifo_level); end
    n_cmp++; if (bad_frame_a !== 1'b1) begin n_err++; $display("FAIL devaddr_bad: got %b want 1", bad_frame_a); end
    n_cmp++; if (cmd_valid_a !== 1'b0) begin n_err++; $display("FAIL devaddr_valid: got %b want 0", cmd_valid_a); end
    tick();
    n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL good_popped: got %b want 0", cmd_valid); end
    n_cmp++; if (bad_frame_a !== 1'b0) begin n_err++; $display("FAIL devaddr_pulse: got %b want 0", bad_frame_a); end
  endtask

  task automatic test_bad_frame();
    int seen;
    do_frame(32'hE51A_FE00);
    n_cmp++; if (bad_frame !== 1'b1) begin n_err++; $display("FAIL bad_addr_pulse: got %b want 1", bad_frame); end
    n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL bad_addr_valid: got %b want 0", cmd_valid); end
    tick();
    n_cmp++; if (bad_frame !== 1'b0) begin n_err++; $display("FAIL bad_addr_clear: got %b want 0", bad_frame); end
    do_frame(32'hE41A_FF00);
    n_cmp++; if (bad_frame !== 1'b1) begin n_err++; $display("FAIL bad_cmd_pulse: got %b want 1", bad_frame); end
    n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL bad_cmd_valid: got %b want 0", cmd_valid); end
    // good frame, then a bad one must drop the hold so later repeats are ignored
    do_frame(nec(8'h00, 8'h55));
    tick();
    do_frame(32'hE51A_FE00);
    seen = 0;
    for (int k = 0; k < 26; k++) begin
      do_repeat();
      if (cmd_valid === 1'b1) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL bad_to_idle: got %0d pushes want 0", seen); end
  endtask

  task automatic test_repeat();
    logic exp;
    cmd_ready = 1'b1;
    do_frame(nec(8'h00, 8'h1A));
    n_cmp++; if (cmd_is_repeat !== 1'b0) begin n_err++; $display("FAIL rep_first_rpt: got %b want 0", cmd_is_repeat); end
    for (int k = 1; k <= 60; k++) begin
      repeat_pulse = (k % 4 == 0);
      tick();
      repeat_pulse = 1'b0;
      exp = (k == 24) || (k == 32) || (k == 40) || (k == 48) || (k == 56);
      n_cmp++; if (cmd_valid !== exp) begin n_err++; $display("FAIL rep_valid_%0d: got %b want %b", k, cmd_valid, exp); end
      if (exp) begin
        n_cmp++; if (cmd_data !== 8'h1A) begin n_err++; $display("FAIL rep_data_%0d: got %h want 1a", k, cmd_data); end
        n_cmp++; if (cmd_is_repeat !== 1'b1) begin n_err++; $display("FAIL rep_flag_%0d: got %b want 1", k, cmd_is_repeat); end
      end
    end
  endtask

  task automatic test_timeout();
    do_frame(nec(8'h00, 8'h1A));
    for (int k = 1; k <= 31; k++) tick();
    do_repeat();
    n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL timeout_valid: got %b want 0", cmd_valid); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL timeout_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_fifo_full();
    cmd_ready = 1'b0;
    for (int c = 1; c <= 6; c++) do_frame(nec(8'h00, 8'(c)));
    n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL full_level: got %0d want 4", fifo_level); end
    n_cmp++; if (drop_cnt !== 8'd2) begin n_err++; $display("FAIL full_drop: got %0d want 2", drop_cnt); end
    cmd_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      n_cmp++; if ((cmd_valid !== 1'b1) || (cmd_data !== 8'(c))) begin
        n_err++; $display("FAIL drain_%0d: got v=%b d=%h want v=1 d=%h", c, cmd_valid, cmd_data, 8'(c));
      end
      tick();
    end
    n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b want 0", cmd_valid); end
    n_cmp++; if (cmd_data !== 8'h04) begin n_err++; $display("FAIL drain_hold: got %h want 04", cmd_data); end
  endtask

  task automatic test_back_to_back();
    cmd_ready = 1'b0;
    for (int c = 7; c <= 10; c++) do_frame(nec(8'h00, 8'(c)));
    cmd_ready = 1'b1;
    do_frame(nec(8'h00, 8'h0B));
    n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL b2b_level: got %0d want 4", fifo_level); end
    n_cmp++; if (drop_cnt !== 8'd2) begin n_err++; $display("FAIL b2b_drop: got %0d want 2", drop_cnt); end
    for (int c = 8; c <= 11; c++) begin
      n_cmp++; if ((cmd_valid !== 1'b1) || (cmd_data !== 8'(c))) begin
        n_err++; $display("FAIL b2b_order_%0d: got v=%b d=%h want v=1 d=%h", c, cmd_valid, cmd_data, 8'(c));
      end
      tick();
    end
    n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got %b want 0", cmd_valid); end
  endtask

  task automatic test_reset_mid_hold();
    cmd_ready = 1'b0;
    for (int c = 12; c <= 14; c++) do_frame(nec(8'h00, 8'(c)));
    n_cmp++; if (fifo_level !== 3'd3) begin n_err++; $display("FAIL mid_level_pre: got %0d want 3", fifo_level); end
    for (int k = 0; k < 22; k++) tick();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", cmd_valid); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL mid_rst_level: got %0d want 0", fifo_level); end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL mid_rst_drop: got %0d want 0", drop_cnt); end
    tick();
    rst = 1'b0;
    cmd_ready = 1'b1;
    do_repeat();
    n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_repeat: got %b want 0", cmd_valid); end
    tick();
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL mid_rst_level_post: got %0d want 0", fifo_level); end
    n_cmp++; if ((cmd_data_a !== 8'h00) || (cmd_is_repeat_a !== 1'b0) || (drop_cnt_a !== 8'd0) || (fifo_level_a !== 3'd0)) begin
      n_err++; $display("FAIL devaddr_idle: got d=%h r=%b dr=%0d l=%0d want all zero", cmd_data_a, cmd_is_repeat_a, drop_cnt_a, fifo_level_a);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_good_frame();
    test_bad_frame();
    test_repeat();
    test_timeout();
    test_fifo_full();
    test_back_to_back();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
